gate_bist_checker: RTL and testbench
====================================

# gate_bist_checker

On-chip built-in self-test for the digital-gates block: the checker drives both gate inputs through all four combinations, samples the 8-bit gate response after a programmable settle time, and compares each sample against a golden truth table. It reports busy/done/pass and a sticky per-gate error mask. The block sits beside the gates block inside the top-level wrapper, connecting `stim` to the gate inputs `ui_in[1:0]` and `resp` to the gate outputs.

## Interface
- `SETTLE_CYCLES`, default 2: wait cycles between a stimulus change and the response sample; legal range 1..255.
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous reset, active-high
- `start`  in  1  run request; sampled only in IDLE or DONE
- `stim`  out  2  gate inputs, registered: `stim[0]` = a → `ui_in[0]`, `stim[1]` = b → `ui_in[1]`
- `resp`  in  8  gate outputs; bit map 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT a, 7 NOT b
- `busy`  out  1  run in progress
- `done`  out  1  run complete; held high until the next accepted start
- `pass`  out  1  valid while `done`=1; 1 when all four vectors matched
- `err_mask`  out  8  sticky OR of mismatching response bits over the run
- `fail_valid`, `fail_vec[1:0]`, `fail_resp[7:0]`  out  present only with `GATE_BIST_ERRLOG_EN`

## Operation
- Vector order by index i = 0..3: a = i[1], b = i[0], giving (a,b) = 00, 01, 10, 11.
- Expected responses: i0 = 0xF8, i1 = 0x4E, i2 = 0x8E, i3 = 0x23.
- FSM states are IDLE, SETTLE, CHECK, and DONE.
  - IDLE/DONE with `start`=1: clear `done`, `pass`, `err_mask` and the error log; set `stim`=00 and the vector index to 0; load the settle counter with SETTLE_CYCLES-1; go to SETTLE.
  - SETTLE: decrement the counter; at 0 go to CHECK.
  - CHECK: `err_mask |= resp ^ expected[i]`.
    - If i=3, go to DONE. `pass` = (final `err_mask`==0), `done`=1.
    - Otherwise i++, `stim` = next vector, reload the counter, and go to SETTLE.
- `busy` = 1 in SETTLE and CHECK.
- `start` during SETTLE/CHECK is ignored; there is no abort.
- The run always completes all four vectors. A mismatch does not stop the run.
- Reset values: state IDLE, `stim`=00, `busy`=0, `done`=0, `pass`=0, `err_mask`=0x00, `fail_*`=0.
- Reset mid-run returns all outputs to the reset values immediately. No partial result is retained.

## Timing
- `start` is registered at edge k. `busy` and `stim`=00 are visible after edge k.
- Each vector takes SETTLE_CYCLES+1 cycles. `stim` changes on the edge that ends CHECK.
- `resp` is compared at the edge ending CHECK, i.e. SETTLE_CYCLES+1 edges after the `stim` change.
- `done` and `pass` rise, and `busy` falls, after edge k + 4·(SETTLE_CYCLES+1). With the default this is k+12.
- In DONE, a `start` high at edge m begins a new run with identical timing: `done` falls after edge m.
- `err_mask` updates after each CHECK edge. It is monotonic within a run.

## Configuration
- `GATE_BIST_ERRLOG_EN` defined:
  - At the first CHECK with a nonzero mismatch, capture the index into `fail_vec` and the raw `resp` into `fail_resp`, and set `fail_valid`.
  - Later mismatches do not overwrite the log.
  - The log is cleared on an accepted start and on reset.
- `GATE_BIST_ERRLOG_EN` undefined: `fail_*` ports and their registers are absent. All other behaviour is identical.

## Structure
- `gate_bist_pkg` holds:
  - the FSM state enum;
  - the gate bit-index constants (AND..NOT b);
  - the 4×8 expected-response constant array;
  - the vector count 4.
- Sub-module `gate_bist_ref_model`: combinational, (a,b) → expected 8-bit response. It is used for the compare and is cross-checked in the bench against the package table.

## Test plan
- Reset, then `start` pulse with a correct gate model on `resp` → `stim` steps 00,01,10,11 every 3 cycles; `done`=1, `pass`=1, `err_mask`=0x00 after 12 cycles.
- Model with the XOR bit stuck at 0 → `pass`=0, `err_mask`=0x04. With ERRLOG: `fail_vec`=1, `fail_resp`=0x4A.
- Model with NOT b inverted → `err_mask`=0x80, `fail_vec`=0. `done` timing unchanged.
- `start` held high throughout a run → ignored while busy. A new run starts from DONE, and `done` drops for 12 cycles.
- Assert `rst` at cycle 7 of a run → all outputs return to their reset values asynchronously. A following `start` gives a clean pass.
- SETTLE_CYCLES=1 and SETTLE_CYCLES=5 → `done` after 8 and 24 cycles respectively; sample points are exactly SETTLE_CYCLES+1 edges after each `stim` change.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate BIST checker: FSM states, response bit
// positions, the golden truth table and the stimulus encoding helper.
package gate_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CHECK,
      ST_DONE
   } state_t;

   localparam int BIT_AND   = 0;
   localparam int BIT_OR    = 1;
   localparam int BIT_XOR   = 2;
   localparam int BIT_NAND  = 3;
   localparam int BIT_NOR   = 4;
   localparam int BIT_XNOR  = 5;
   localparam int BIT_NOT_A = 6;
   localparam int BIT_NOT_B = 7;

   localparam int NUM_VECTORS = 4;

   // Golden responses indexed by vector number i, where a = i[1], b = i[0].
   localparam logic [NUM_VECTORS-1:0][7:0] EXPECTED_RESP = {8'h23, 8'h8E, 8'h4E, 8'hF8};

   // Vector index to gate-input bus: stim[0] carries a (= i[1]), stim[1] carries b (= i[0]).
   function automatic logic [1:0] vec_to_stim(input logic [1:0] idx);
      return {idx[0], idx[1]};
   endfunction

endpackage

// File: rtl/gate_bist_ref_model.sv
// Combinational golden model of the gates block: (a,b) -> expected 8-bit response.
module gate_bist_ref_model
   import gate_bist_pkg::*;
(
   input  logic       a,
   input  logic       b,
   output logic [7:0] resp_exp
);

   // Evaluate every gate from its definition so the table can be cross-checked.
   always_comb begin
      resp_exp            = '0;
      resp_exp[BIT_AND]   = a & b;
      resp_exp[BIT_OR]    = a | b;
      resp_exp[BIT_XOR]   = a ^ b;
      resp_exp[BIT_NAND]  = ~(a & b);
      resp_exp[BIT_NOR]   = ~(a | b);
      resp_exp[BIT_XNOR]  = ~(a ^ b);
      resp_exp[BIT_NOT_A] = ~a;
      resp_exp[BIT_NOT_B] = ~b;
   end

endmodule

// File: rtl/gate_bist_checker.sv
// Built-in self-test for the gates block. Walks (a,b) through 00,01,10,11,
// waits SETTLE_CYCLES (legal 1..255) after each stimulus change, compares the
// response against the reference model and accumulates a sticky error mask.
// Optional error log of the first failing vector: define GATE_BIST_ERRLOG_EN.
module gate_bist_checker
   import gate_bist_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [1:0] stim,
   input  logic [7:0] resp,
   output logic       busy,
   output logic       done,
   output logic       pass,
`ifdef GATE_BIST_ERRLOG_EN
   output logic       fail_valid,
   output logic [1:0] fail_vec,
   output logic [7:0] fail_resp,
`endif
   output logic [7:0] err_mask
);

   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

   state_t     state;
   logic [1:0] idx;
   logic [7:0] settle_cnt;
   logic [7:0] resp_exp;
   logic [7:0] mismatch;

   // The reference is driven from the vector index, not from stim, so a
   // wiring error on the stimulus path shows up as a mismatch.
   gate_bist_ref_model u_ref (
      .a        (idx[1]),
      .b        (idx[0]),
      .resp_exp (resp_exp)
   );

   // Bits that disagree with the golden response for the current vector.
   always_comb begin
      mismatch = resp ^ resp_exp;
   end

   // Sequencer: settle, sample, advance; all outputs are registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         idx        <= '0;
         settle_cnt <= '0;
         stim       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_mask   <= '0;
`ifdef GATE_BIST_ERRLOG_EN
         fail_valid <= 1'b0;
         fail_vec   <= '0;
         fail_resp  <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state      <= ST_SETTLE;
                  idx        <= '0;
                  settle_cnt <= SETTLE_LOAD;
                  stim       <= vec_to_stim(2'd0);
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  err_mask   <= '0;
`ifdef GATE_BIST_ERRLOG_EN
                  fail_valid <= 1'b0;
                  fail_vec   <= '0;
                  fail_resp  <= '0;
`endif
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == 8'd0) begin
                  state <= ST_CHECK;
               end else begin
                  settle_cnt <= settle_cnt - 8'd1;
               end
            end
            ST_CHECK: begin
               err_mask <= err_mask | mismatch;
`ifdef GATE_BIST_ERRLOG_EN
               if (!fail_valid && (mismatch != 8'h00)) begin
                  fail_valid <= 1'b1;
                  fail_vec   <= idx;
                  fail_resp  <= resp;
               end
`endif
               if (idx == 2'(NUM_VECTORS - 1)) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= ((err_mask | mismatch) == 8'h00);
               end else begin
                  state      <= ST_SETTLE;
                  idx        <= idx + 2'd1;
                  stim       <= vec_to_stim(idx + 2'd1);
                  settle_cnt <= SETTLE_LOAD;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_bist_checker.sv
// Self-checking bench for gate_bist_checker: three instances (settle 2, 1, 5)
// each fed by a behavioural gates block with selectable faults.
module tb_gate_bist_checker;
   import gate_bist_pkg::*;

   localparam int NUM_DUT = 3;
   localparam int SETTLE_TAB [NUM_DUT] = '{2, 1, 5};

   typedef struct {
      logic       pass;
      logic [7:0] err;
      logic       fvalid;
      logic [1:0] fvec;
      logic [7:0] fresp;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         fault = 0;
   logic       start_v    [NUM_DUT];
   logic [1:0] stim_v     [NUM_DUT];
   logic [7:0] resp_v     [NUM_DUT];
   logic       busy_v     [NUM_DUT];
   logic       done_v     [NUM_DUT];
   logic       pass_v     [NUM_DUT];
   logic [7:0] err_v      [NUM_DUT];
`ifdef GATE_BIST_ERRLOG_EN
   logic       fvalid_v   [NUM_DUT];
   logic [1:0] fvec_v     [NUM_DUT];
   logic [7:0] fresp_v    [NUM_DUT];
`endif

   int   compared   = 0;
   int   mismatched = 0;
   exp_t sb_q [$];

   logic       ref_a, ref_b;
   logic [7:0] ref_out;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NUM_DUT; g++) begin : g_dut
      gate_bist_checker #(.SETTLE_CYCLES(SETTLE_TAB[g])) dut (
         .clk        (clk),
         .rst        (rst),
         .start      (start_v[g]),
         .stim       (stim_v[g]),
         .resp       (resp_v[g]),
         .busy       (busy_v[g]),
         .done       (done_v[g]),
         .pass       (pass_v[g]),
`ifdef GATE_BIST_ERRLOG_EN
         .fail_valid (fvalid_v[g]),
         .fail_vec   (fvec_v[g]),
         .fail_resp  (fresp_v[g]),
`endif
         .err_mask   (err_v[g])
      );
   end

   gate_bist_ref_model u_ref_chk (
      .a        (ref_a),
      .b        (ref_b),
      .resp_exp (ref_out)
   );

   // Bench's own truth table for the gates block, written from the gate list.
   function automatic logic [7:0] golden(input logic a, input logic b);
      return {~b, ~a, ~(a ^ b), ~(a | b), ~(a & b), a ^ b, a | b, a & b};
   endfunction

   // Behavioural gates block with planted faults: 1 = XOR stuck 0, 2 = NOT b inverted.
   function automatic logic [7:0] model_resp(input logic [1:0] s, input int f);
      logic [7:0] r;
      r = golden(s[0], s[1]);
      if (f == 1) r[2] = 1'b0;
      if (f == 2) r[7] = ~r[7];
      return r;
   endfunction

   // Drive every instance's resp from its stim through the gates model.
   always_comb begin
      for (int i = 0; i < NUM_DUT; i++) begin
         resp_v[i] = model_resp(stim_v[i], fault);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      for (int i = 0; i < NUM_DUT; i++) begin
         check_output({tag, "_busy"}, 8'(busy_v[i]), 8'h00);
         check_output({tag, "_done"}, 8'(done_v[i]), 8'h00);
         check_output({tag, "_pass"}, 8'(pass_v[i]), 8'h00);
         check_output({tag, "_stim"}, 8'(stim_v[i]), 8'h00);
         check_output({tag, "_err"}, err_v[i], 8'h00);
`ifdef GATE_BIST_ERRLOG_EN
         check_output({tag, "_fvalid"}, 8'(fvalid_v[i]), 8'h00);
         check_output({tag, "_fvec"}, 8'(fvec_v[i]), 8'h00);
         check_output({tag, "_fresp"}, fresp_v[i], 8'h00);
`endif
      end
   endtask

   // Predict the run result from the current fault and queue it.
   task automatic push_expected;
      exp_t       e;
      logic [7:0] diff;
      logic [1:0] iv;
      e.err = 8'h00; e.fvalid = 1'b0; e.fvec = 2'd0; e.fresp = 8'h00;
      for (int i = 0; i < 4; i++) begin
         iv   = 2'(i);
         diff = model_resp({iv[0], iv[1]}, fault) ^ golden(iv[1], iv[0]);
         if (diff != 8'h00 && !e.fvalid) begin
            e.fvalid = 1'b1;
            e.fvec   = iv;
            e.fresp  = model_resp({iv[0], iv[1]}, fault);
         end
         e.err |= diff;
      end
      e.pass = (e.err == 8'h00);
      sb_q.push_back(e);
   endtask

   // One full run on instance w: start edge, cycle-exact stim/busy/done
   // tracking, then scoreboard pop when done must be up. hold keeps start high.
   task automatic apply_stimulus(input int w, input bit hold);
      int         per, total;
      logic [1:0] iv;
      exp_t       e;
      per   = SETTLE_TAB[w] + 1;
      total = 4 * per;
      start_v[w] = 1'b1;
      push_expected();
      tick();
      if (!hold) start_v[w] = 1'b0;
      check_output("start_busy", 8'(busy_v[w]), 8'h01);
      check_output("start_done", 8'(done_v[w]), 8'h00);
      check_output("start_stim", 8'(stim_v[w]), 8'h00);
      for (int c = 1; c <= total; c++) begin
         tick();
         if (c < total) begin
            iv = 2'(c / per);
            check_output("run_busy", 8'(busy_v[w]), 8'h01);
            check_output("run_done", 8'(done_v[w]), 8'h00);
            check_output("run_stim", 8'(stim_v[w]), 8'({iv[0], iv[1]}));
         end else begin
            check_output("end_busy", 8'(busy_v[w]), 8'h00);
            check_output("end_done", 8'(done_v[w]), 8'h01);
            if (sb_q.size() == 0) begin
               check_output("sb_empty", 8'h01, 8'h00);
            end else begin
               e = sb_q.pop_front();
               check_output("end_pass", 8'(pass_v[w]), 8'(e.pass));
               check_output("end_err", err_v[w], e.err);
`ifdef GATE_BIST_ERRLOG_EN
               check_output("end_fvalid", 8'(fvalid_v[w]), 8'(e.fvalid));
               check_output("end_fvec", 8'(fvec_v[w]), 8'(e.fvec));
               check_output("end_fresp", fresp_v[w], e.fresp);
`endif
            end
         end
      end
   endtask

   // Safety net so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      for (int i = 0; i < NUM_DUT; i++) start_v[i] = 1'b0;
      ref_a = 1'b0;
      ref_b = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      rst = 1'b0;
      tick();

      // Reference model against package table and bench truth table.
      for (int i = 0; i < 4; i++) begin
         ref_a = (i >= 2);
         ref_b = (i % 2 == 1);
         #1;
         check_output("ref_vs_pkg", ref_out, EXPECTED_RESP[i]);
         check_output("ref_vs_tb", ref_out, golden(ref_a, ref_b));
      end
      check_output("pkg_vec_count", 8'(NUM_VECTORS), 8'd4);

      $display("[TB] clean run, settle 2");
      fault = 0;
      apply_stimulus(0, 1'b0);

      $display("[TB] XOR stuck at 0");
      fault = 1;
      apply_stimulus(0, 1'b0);
      check_output("xor_err_const", err_v[0], 8'h04);

      $display("[TB] NOT b inverted");
      fault = 2;
      apply_stimulus(0, 1'b0);
      check_output("notb_err_const", err_v[0], 8'h80);

      $display("[TB] start held through two runs");
      fault = 0;
      apply_stimulus(0, 1'b1);
      apply_stimulus(0, 1'b0);
      tick();
      check_output("idle_after_hold_done", 8'(done_v[0]), 8'h01);
      check_output("idle_after_hold_busy", 8'(busy_v[0]), 8'h00);

      $display("[TB] reset mid-run");
      fault = 2;
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      repeat (6) tick();
      check_output("prereset_err", err_v[0], 8'h80);
      #2 rst = 1'b1;
      #1;
      check_reset_state("midrun_reset");
      @(posedge clk);
      #1 rst = 1'b0;
      fault = 0;
      apply_stimulus(0, 1'b0);

      $display("[TB] settle 1 and settle 5");
      apply_stimulus(1, 1'b0);
      apply_stimulus(2, 1'b0);
      fault = 1;
      apply_stimulus(2, 1'b0);

      check_output("sb_drained", 8'(sb_q.size()), 8'h00);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
